// File: rtl/axis_sink_pkg.sv
// ---------------------------------------------------------------------------
// axis_sink_pkg
// Shared definitions for the AXI-Stream output sink monitor: default widths,
// FSM state encodings and a small helper that tells which states drive the
// TREADY pattern.
// ---------------------------------------------------------------------------
package axis_sink_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_PAT_W       = 16;
    localparam int DEF_STALL_LIMIT = 1024;

    typedef logic [1:0] sink_state_t;

    localparam sink_state_t ST_IDLE    = 2'd0;
    localparam sink_state_t ST_RECV    = 2'd1;
    localparam sink_state_t ST_STALLED = 2'd2;
    localparam sink_state_t ST_DONE    = 2'd3;

    // The backpressure pattern keeps running while stalled so the beat that
    // ends the starvation can be accepted immediately.
    function automatic logic state_is_active(input sink_state_t s);
        return (s == ST_RECV) || (s == ST_STALLED);
    endfunction

endpackage

// File: rtl/axis_ready_pattern_gen.sv
// ---------------------------------------------------------------------------
// axis_ready_pattern_gen
// Produces the registered TREADY of the sink by stepping through a
// programmable bit pattern, one slot per cycle while enabled.
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst_n     synchronous active-low reset
//   enable       high when the sink will be receiving in the next cycle
//   cfg_pattern  bit i gives the ready value for pattern slot i
//   ready        registered TREADY, low whenever not enabled
// ---------------------------------------------------------------------------
import axis_sink_pkg::*;

module axis_ready_pattern_gen #(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             enable,
    input  logic [PAT_W-1:0] cfg_pattern,
    output logic             ready
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    logic [IDX_W-1:0] idx;

    // The index advances every enabled cycle regardless of traffic, so the
    // ready waveform is a pure function of time spent receiving. Because
    // enable is derived from the next state, ready drops in the same edge
    // the sink leaves the receiving states.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            idx   <= '0;
            ready <= 1'b0;
        end else if (enable) begin
            ready <= cfg_pattern[idx];
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            ready <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_output_sink_monitor.sv
// ---------------------------------------------------------------------------
// axis_output_sink_monitor
// Co-simulation sink for the kernel's output_r AXI-Stream port. Drains the
// stream under a programmable TREADY pattern, counts beats and packets,
// checks TLAST placement against an expected packet length and flags
// starvation (kernel busy but no TVALID for STALL_LIMIT cycles).
// Ports:
//   ap_clk, ap_rst_n      clock and synchronous active-low reset
//   s_axis_*              AXI-Stream slave (tdata/tvalid/tlast in, tready out)
//   cfg_pattern           TREADY pattern, one bit per cycle slot
//   cfg_pkt_len           expected beats per packet, 0 disables TLAST check
//   cfg_num_pkts          packets to accept before done, 0 = unbounded
//   kernel_idle           kernel ap_idle
//   beat_cnt, pkt_cnt     accepted beat / packet counters (wrap silently)
//   last_data             TDATA of the latest accepted beat
//   beat_pulse            one-cycle pulse after each accepted beat
//   err_tlast, stall      sticky error flags
//   done                  requested packet count reached
// ---------------------------------------------------------------------------
import axis_sink_pkg::*;

module axis_output_sink_monitor #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PAT_W       = DEF_PAT_W,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_pkt_len,
    input  logic [CNT_W-1:0]  cfg_num_pkts,
    input  logic              kernel_idle,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [DATA_W-1:0] last_data,
    output logic              beat_pulse,
    output logic              err_tlast,
    output logic              stall,
    output logic              done
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    sink_state_t        state;
    sink_state_t        state_next;
    logic [STALL_W-1:0] stall_run;
    logic [CNT_W-1:0]   beat_in_pkt;
    logic [CNT_W-1:0]   beat_pos;
    logic [CNT_W-1:0]   pkt_next;
    logic               accept;
    logic               starved;
    logic               stall_hit;
    logic               finish_pkt;

    assign accept   = s_axis_tvalid && s_axis_tready;
    // Backpressured cycles (TVALID high, TREADY low) are not starvation.
    assign starved  = !kernel_idle && !s_axis_tvalid;
    assign beat_pos = beat_in_pkt + 1'b1;
    assign pkt_next = pkt_cnt + 1'b1;
    assign finish_pkt = accept && s_axis_tlast && (cfg_num_pkts != '0)
                        && (pkt_next == cfg_num_pkts);
    // Fires on the cycle whose count would bring stall_run to the limit.
    assign stall_hit = (state == ST_RECV) && starved
                       && (stall_run == STALL_MAX - 1'b1);

    axis_ready_pattern_gen #(
        .PAT_W (PAT_W)
    ) u_ready_gen (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .enable      (state_is_active(state_next)),
        .cfg_pattern (cfg_pattern),
        .ready       (s_axis_tready)
    );

    // Next-state logic. Completing the final packet takes priority so the
    // last beat is always counted before the sink closes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!kernel_idle || s_axis_tvalid) state_next = ST_RECV;
            end
            ST_RECV: begin
                if (finish_pkt)     state_next = ST_DONE;
                else if (stall_hit) state_next = ST_STALLED;
            end
            ST_STALLED: begin
                if (finish_pkt)         state_next = ST_DONE;
                else if (s_axis_tvalid) state_next = ST_RECV;
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus the flags that follow state transitions.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            stall_run <= '0;
            stall     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_RECV && starved && !stall_hit) begin
                if (stall_run != STALL_MAX) stall_run <= stall_run + 1'b1;
            end else begin
                stall_run <= '0;
            end
            if (stall_hit)               stall <= 1'b1;
            if (state_next == ST_DONE)   done  <= 1'b1;
        end
    end

    // Beat and packet accounting for every accepted handshake.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            beat_cnt   <= '0;
            pkt_cnt    <= '0;
            last_data  <= '0;
            beat_pulse <= 1'b0;
        end else begin
            beat_pulse <= accept;
            if (accept) begin
                beat_cnt  <= beat_cnt + 1'b1;
                last_data <= s_axis_tdata;
                if (s_axis_tlast) pkt_cnt <= pkt_next;
            end
        end
    end

    // TLAST placement check. The position counter restarts on any TLAST and
    // after the nominal last beat, so a malformed packet does not poison the
    // check of the one that follows.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            beat_in_pkt <= '0;
            err_tlast   <= 1'b0;
        end else if (accept) begin
            if (cfg_pkt_len == '0) begin
                beat_in_pkt <= '0;
            end else begin
                if (s_axis_tlast && (beat_pos < cfg_pkt_len))   err_tlast <= 1'b1;
                if (!s_axis_tlast && (beat_pos == cfg_pkt_len)) err_tlast <= 1'b1;
                beat_in_pkt <= (s_axis_tlast || (beat_pos >= cfg_pkt_len)) ? '0 : beat_pos;
            end
        end
    end

endmodule

// File: tb/tb_axis_output_sink_monitor.sv
`timescale 1ns/1ps
module tb_axis_output_sink_monitor;
    import axis_sink_pkg::*;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 32;
    localparam int PAT_W       = 16;
    localparam int STALL_LIMIT = 8;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic [PAT_W-1:0]  cfg_pattern;
    logic [CNT_W-1:0]  cfg_pkt_len;
    logic [CNT_W-1:0]  cfg_num_pkts;
    logic              kernel_idle;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [DATA_W-1:0] last_data;
    logic              beat_pulse;
    logic              err_tlast;
    logic              stall;
    logic              done;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_beats    = 0;
    logic [DATA_W-1:0] sb_queue[$];

    axis_output_sink_monitor #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .PAT_W       (PAT_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .cfg_pattern   (cfg_pattern),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_num_pkts  (cfg_num_pkts),
        .kernel_idle   (kernel_idle),
        .beat_cnt      (beat_cnt),
        .pkt_cnt       (pkt_cnt),
        .last_data     (last_data),
        .beat_pulse    (beat_pulse),
        .err_tlast     (err_tlast),
        .stall         (stall),
        .done          (done)
    );

    always #5 ap_clk = ~ap_clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Hold reset for two edges, then clear the scoreboard.
    task automatic doReset();
        ap_rst_n      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        kernel_idle   = 1'b1;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        sb_queue.delete();
        exp_beats = 0;
    endtask

    // Offer one beat (called on a negedge) and wait, bounded, for acceptance.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic last);
        logic hs;
        int   waited;
        hs     = 1'b0;
        waited = 0;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        sb_queue.push_back(data);
        while (!hs && waited < 40) begin
            hs = s_axis_tready;
            @(negedge ap_clk);
            waited++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checkOutput($sformatf("beat_accept_%0h", data), 64'(hs), 64'd1);
        if (!hs) void'(sb_queue.pop_back());
    endtask

    // Every beat_pulse must match the oldest outstanding driven beat.
    always @(negedge ap_clk) begin
        if (ap_rst_n && beat_pulse) begin
            exp_beats++;
            if (sb_queue.size() == 0) begin
                checkOutput("sb_underflow", 64'(sb_queue.size()), 64'd1);
            end else begin
                checkOutput("last_data", 64'(last_data), 64'(sb_queue.pop_front()));
            end
            checkOutput("beat_cnt_track", 64'(beat_cnt), 64'(exp_beats));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic hs;
        int   accepted;
        int   ready_seen;

        ap_rst_n      = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_pattern   = 16'hFFFF;
        cfg_pkt_len   = 32'd4;
        cfg_num_pkts  = 32'd2;
        kernel_idle   = 1'b1;
        doReset();

        // Reset state
        checkOutput("rst_tready", 64'(s_axis_tready), 64'd0);
        checkOutput("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        checkOutput("rst_last_data", 64'(last_data), 64'd0);
        checkOutput("rst_flags", 64'({beat_pulse, err_tlast, stall, done}), 64'd0);
        checkOutput("rst_state", 64'(dut.state), 64'(ST_IDLE));

        // Two 4-beat packets back to back, then DONE
        $display("[TB] two packets of four beats");
        for (int i = 1; i <= 8; i++) applyStimulus(32'hA000_0000 + 32'(i), (i % 4) == 0);
        checkOutput("p2_beat_cnt", 64'(beat_cnt), 64'd8);
        checkOutput("p2_pkt_cnt", 64'(pkt_cnt), 64'd2);
        checkOutput("p2_done", 64'(done), 64'd1);
        checkOutput("p2_err", 64'(err_tlast), 64'd0);
        checkOutput("p2_last_data", 64'(last_data), 64'hA000_0008);
        checkOutput("p2_state", 64'(dut.state), 64'(ST_DONE));
        s_axis_tvalid = 1'b1;
        ready_seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (s_axis_tready) ready_seen++;
            @(negedge ap_clk);
        end
        s_axis_tvalid = 1'b0;
        checkOutput("done_no_ready", 64'(ready_seen), 64'd0);
        checkOutput("done_beat_hold", 64'(beat_cnt), 64'd8);

        // Alternating ready pattern with TVALID held high
        $display("[TB] alternating backpressure");
        doReset();
        cfg_pattern  = 16'h5555;
        cfg_pkt_len  = '0;
        cfg_num_pkts = '0;
        s_axis_tdata  = 32'h0000_0100;
        s_axis_tvalid = 1'b1;
        @(negedge ap_clk);
        accepted = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            hs = s_axis_tready;
            checkOutput($sformatf("alt_ready_%0d", cyc), 64'(hs), 64'((cyc % 2) == 0));
            if (hs) sb_queue.push_back(s_axis_tdata);
            @(negedge ap_clk);
            if (hs) begin
                accepted++;
                s_axis_tdata = s_axis_tdata + 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
        checkOutput("alt_accepted", 64'(accepted), 64'd10);
        checkOutput("alt_beat_cnt", 64'(beat_cnt), 64'd10);

        // Early TLAST on beat 3 of 4, then a clean packet
        $display("[TB] early tlast");
        doReset();
        cfg_pattern = 16'hFFFF;
        cfg_pkt_len = 32'd4;
        applyStimulus(32'hB1, 1'b0);
        applyStimulus(32'hB2, 1'b0);
        checkOutput("early_err_before", 64'(err_tlast), 64'd0);
        applyStimulus(32'hB3, 1'b1);
        checkOutput("early_err_after", 64'(err_tlast), 64'd1);
        for (int i = 1; i <= 4; i++) applyStimulus(32'hC0 + 32'(i), i == 4);
        checkOutput("early_pkt_cnt", 64'(pkt_cnt), 64'd2);
        checkOutput("early_pos_restart", 64'(dut.beat_in_pkt), 64'd0);
        checkOutput("early_err_sticky", 64'(err_tlast), 64'd1);

        // Missing TLAST on the nominal last beat
        $display("[TB] missing tlast");
        doReset();
        cfg_pkt_len = 32'd2;
        applyStimulus(32'hD1, 1'b0);
        checkOutput("late_err_before", 64'(err_tlast), 64'd0);
        applyStimulus(32'hD2, 1'b0);
        checkOutput("late_err_after", 64'(err_tlast), 64'd1);

        // Starvation with the kernel busy
        $display("[TB] starvation");
        doReset();
        cfg_pkt_len = '0;
        kernel_idle = 1'b0;
        @(negedge ap_clk);
        for (int c = 0; c < STALL_LIMIT - 1; c++) @(negedge ap_clk);
        checkOutput("stall_before_limit", 64'(stall), 64'd0);
        @(negedge ap_clk);
        checkOutput("stall_at_limit", 64'(stall), 64'd1);
        checkOutput("stall_state", 64'(dut.state), 64'(ST_STALLED));
        applyStimulus(32'hE1, 1'b0);
        checkOutput("stall_recover_state", 64'(dut.state), 64'(ST_RECV));
        checkOutput("stall_sticky", 64'(stall), 64'd1);
        checkOutput("stall_beat_cnt", 64'(beat_cnt), 64'd1);
        kernel_idle = 1'b1;

        // All-zero pattern: writer blocked, no starvation
        $display("[TB] zero pattern");
        doReset();
        cfg_pattern   = 16'h0000;
        kernel_idle   = 1'b0;
        s_axis_tdata  = 32'hF00D;
        s_axis_tvalid = 1'b1;
        ready_seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (s_axis_tready) ready_seen++;
            @(negedge ap_clk);
        end
        checkOutput("zero_ready", 64'(ready_seen), 64'd0);
        checkOutput("zero_beat_cnt", 64'(beat_cnt), 64'd0);
        checkOutput("zero_stall", 64'(stall), 64'd0);
        s_axis_tvalid = 1'b0;

        // Reset in the middle of a packet
        $display("[TB] reset mid-packet");
        doReset();
        cfg_pattern = 16'hFFFF;
        cfg_pkt_len = 32'd4;
        applyStimulus(32'h11, 1'b0);
        applyStimulus(32'h12, 1'b0);
        doReset();
        checkOutput("mid_beat_cnt", 64'(beat_cnt), 64'd0);
        checkOutput("mid_pkt_cnt", 64'(pkt_cnt), 64'd0);
        checkOutput("mid_err", 64'(err_tlast), 64'd0);
        checkOutput("mid_tready", 64'(s_axis_tready), 64'd0);
        for (int i = 1; i <= 4; i++) applyStimulus(32'h20 + 32'(i), i == 4);
        checkOutput("mid_new_err", 64'(err_tlast), 64'd0);
        checkOutput("mid_new_pkt", 64'(pkt_cnt), 64'd1);
        checkOutput("mid_new_beats", 64'(beat_cnt), 64'd4);

        @(negedge ap_clk);
        checkOutput("sb_empty", 64'(sb_queue.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
